diff_flag_stage: RTL and testbench

DIFF_FLAG_STAGE -- requirements
Module: diff_flag_stage

---
 rtl/diff_flag_stage.sv | 133 +++++++++++++
 tb/tb_diff_flag_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/diff_flag_stage.sv
// rtl/diff_flag_stage.sv - subtractor result checker with comparison flags and a 2-entry output FIFO
module diff_flag_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] Diff,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] Diff_q,
  output logic       EQ,
  output logic       GT,
  output logic       LT,
  output logic       Borrow,
  output logic       Zero,
  output logic       Err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Flags are resolved at accept time so the head drives outputs straight from flops.
  // Borrow is identical to LT for an unsigned subtract, so it is not stored separately.
  typedef struct packed {
    logic [3:0] diff;
    logic       eq;
    logic       gt;
    logic       lt;
    logic       zero;
    logic       err;
  } entry_t;

  state_t     state;
  entry_t     slot0;      // head of the FIFO; all-zero whenever the FIFO is empty
  entry_t     slot1;
  entry_t     new_entry;
  logic [3:0] wrapped_diff;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       push;
  logic       pop;

  assign push = in_valid & in_ready_r;
  assign pop  = out_valid_r & out_ready;

  // Evaluate the incoming triple into a flag record ready for storage.
  always_comb begin
    wrapped_diff   = A - B;
    new_entry      = '0;
    new_entry.diff = Diff;
    new_entry.eq   = (A == B);
    new_entry.gt   = (A > B);
    new_entry.lt   = (A < B);
    new_entry.zero = (Diff == 4'd0);
    new_entry.err  = (Diff != wrapped_diff);
  end

  // Occupancy FSM with FIFO storage; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      slot0       <= '0;
      slot1       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            slot0       <= new_entry;
            state       <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            slot0 <= new_entry;
          end else if (push) begin
            slot1      <= new_entry;
            state      <= FULL;
            in_ready_r <= 1'b0;
          end else if (pop) begin
            slot0       <= '0;
            state       <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            slot0      <= slot1;
            slot1      <= '0;
            state      <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          slot0       <= '0;
          slot1       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Count popped entries that carried a subtractor error, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (pop && slot0.err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Diff_q    = slot0.diff;
  assign EQ        = slot0.eq;
  assign GT        = slot0.gt;
  assign LT        = slot0.lt;
  assign Borrow    = slot0.lt;
  assign Zero      = slot0.zero;
  assign Err       = slot0.err;

endmodule

// File: tb/tb_diff_flag_stage.sv
// tb/tb_diff_flag_stage.sv - vector table, corner sequences and randomized model check for diff_flag_stage
module tb_diff_flag_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Diff;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Diff_q;
  logic       EQ;
  logic       GT;
  logic       LT;
  logic       Borrow;
  logic       Zero;
  logic       Err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  diff_flag_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Diff     (Diff),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff_q   (Diff_q),
    .EQ       (EQ),
    .GT       (GT),
    .LT       (LT),
    .Borrow   (Borrow),
    .Zero     (Zero),
    .Err      (Err),
    .err_cnt  (err_cnt)
  );

  // Observed outputs packed as {in_ready, out_valid, Diff_q, EQ, GT, LT, Borrow, Zero, Err, err_cnt}
  logic [19:0] act;
  assign act = {in_ready, out_valid, Diff_q, EQ, GT, LT, Borrow, Zero, Err, err_cnt};

  typedef struct {
    int a;
    int b;
    int d;
  } trip_t;

  trip_t q[$];
  int    m_cnt = 0;
  int    checks = 0;
  int    errors = 0;

  typedef struct {
    logic       r;
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [3:0] dq;
    logic [5:0] fl;   // {EQ, GT, LT, Borrow, Zero, Err}
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[24];

  function automatic bit trip_err(trip_t t);
    int wrap;
    wrap = ((t.a - t.b) % 16 + 16) % 16;
    return (t.d != wrap);
  endfunction

  function automatic logic [19:0] model_exp();
    logic [19:0] e;
    trip_t       h;
    logic [3:0]  dq;
    logic [5:0]  fl;
    logic [7:0]  ec;
    ec = m_cnt[7:0];
    if (q.size() == 0) begin
      e = {1'b1, 1'b0, 4'd0, 6'd0, ec};
    end else begin
      h  = q[0];
      dq = h.d[3:0];
      fl = {h.a == h.b, h.a > h.b, h.a < h.b, h.a < h.b, h.d == 0, trip_err(h)};
      e  = {q.size() < 2, 1'b1, dq, fl, ec};
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [3:0] a_i,
                      input logic [3:0] b_i, input logic [3:0] d_i, input logic ordy);
    bit    push_m;
    bit    pop_m;
    trip_t t;
    rst       = r;
    in_valid  = iv;
    A         = a_i;
    B         = b_i;
    Diff      = d_i;
    out_ready = ordy;
    push_m    = iv && (q.size() < 2);
    pop_m     = ordy && (q.size() > 0);
    t.a = int'(a_i);
    t.b = int'(b_i);
    t.d = int'(d_i);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (pop_m) begin
        if (trip_err(q[0]) && m_cnt < 255) m_cnt++;
        void'(q.pop_front());
      end
      if (push_m) q.push_back(t);
    end
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [19:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s[%0d]: got ir=%b ov=%b dq=%0d fl=%b ec=%0d, want ir=%b ov=%b dq=%0d fl=%b ec=%0d",
               name, idx, act[19], act[18], act[17:14], act[13:8], act[7:0],
               exp_v[19], exp_v[18], exp_v[17:14], exp_v[13:8], exp_v[7:0]);
    end
  endtask

  initial begin
    // r iv  a  b  d ordy | ir ov dq flags(EQ GT LT Bw Z Er) ec
    tbl[0]  = '{1, 1, 9, 3, 6,  0, 1, 0, 0,  6'b000000, 0};  // entry in reset cycle dropped
    tbl[1]  = '{0, 1, 9, 3, 6,  1, 1, 1, 6,  6'b010000, 0};  // one-cycle latency, GT
    tbl[2]  = '{0, 1, 3, 9, 10, 1, 1, 1, 10, 6'b001100, 0};  // push+pop in ONE, LT/Borrow
    tbl[3]  = '{0, 1, 7, 7, 0,  1, 1, 1, 0,  6'b100010, 0};  // EQ, Zero
    tbl[4]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0,  6'b000000, 0};  // pop to EMPTY, flags clear
    tbl[5]  = '{0, 1, 0, 1, 15, 0, 1, 1, 15, 6'b001100, 0};  // wrapped diff is not an error
    tbl[6]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0,  6'b000000, 0};
    tbl[7]  = '{0, 1, 5, 2, 4,  0, 1, 1, 4,  6'b010001, 0};  // wrong diff flagged
    tbl[8]  = '{0, 0, 0, 0, 0,  0, 1, 1, 4,  6'b010001, 0};  // head stable under backpressure
    tbl[9]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0,  6'b000000, 1};  // err_cnt 0->1 on pop
    tbl[10] = '{0, 1, 1, 0, 1,  0, 1, 1, 1,  6'b010000, 1};
    tbl[11] = '{0, 1, 2, 0, 2,  0, 0, 1, 1,  6'b010000, 1};  // FULL, in_ready drops
    tbl[12] = '{0, 1, 3, 0, 3,  0, 0, 1, 1,  6'b010000, 1};  // push while FULL ignored
    tbl[13] = '{0, 0, 0, 0, 0,  1, 1, 1, 2,  6'b010000, 1};  // FIFO order
    tbl[14] = '{0, 0, 0, 0, 0,  1, 1, 0, 0,  6'b000000, 1};
    tbl[15] = '{0, 0, 0, 0, 0,  1, 1, 0, 0,  6'b000000, 1};  // out_ready while EMPTY ignored
    tbl[16] = '{0, 1, 0, 0, 1,  0, 1, 1, 1,  6'b100001, 1};
    tbl[17] = '{0, 1, 0, 0, 2,  1, 1, 1, 2,  6'b100001, 2};  // push+pop in ONE shows new entry
    tbl[18] = '{0, 1, 0, 0, 3,  0, 0, 1, 2,  6'b100001, 2};
    tbl[19] = '{0, 0, 0, 0, 0,  1, 1, 1, 3,  6'b100001, 3};
    tbl[20] = '{0, 1, 0, 0, 4,  1, 1, 1, 4,  6'b100001, 4};
    tbl[21] = '{0, 1, 0, 0, 5,  0, 0, 1, 4,  6'b100001, 4};  // FULL with err_cnt=4
    tbl[22] = '{1, 1, 9, 9, 9,  1, 1, 0, 0,  6'b000000, 0};  // reset wins over push/pop
    tbl[23] = '{0, 0, 0, 0, 0,  0, 1, 0, 0,  6'b000000, 0};

    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("reset", 0, {1'b1, 1'b0, 4'd0, 6'd0, 8'd0});

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].ordy);
      check("vec", i, {tbl[i].ir, tbl[i].ov, tbl[i].dq, tbl[i].fl, tbl[i].ec});
    end

    // 300 erroneous entries streamed through with continuous pops
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 4'd5, 4'd2, 4'd4, 1'b1);
      if (i % 50 == 0) check("sat_stream", i, model_exp());
    end
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("sat_final", 0, {1'b1, 1'b0, 4'd0, 6'd0, 8'd255});
    step(1'b0, 1'b1, 4'd5, 4'd2, 4'd4, 1'b1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("sat_hold", 0, {1'b1, 1'b0, 4'd0, 6'd0, 8'd255});

    // Randomized traffic against the queue model
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("rand_reset", 0, model_exp());
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rd;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(ra - rb);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), ra, rb, rd,
           ($urandom_range(0, 2) != 0));
      check("rand", i, model_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
